// File: rtl/div_pkg.sv
// div_pkg: op and state encodings shared by the iterative divider and its bench.
// Rev 1.0
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic is_signed(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on the {acc,quo} pair.
// Rev 1.0
`default_nettype none

module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   acc_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   acc_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // One spare top bit so a failed trial subtraction shows up as a set sign bit.
  assign shifted = {acc_i, quo_i[XLEN-1]};
  assign diff    = shifted - {2'b00, div_i};

  always_comb begin
    acc_o = shifted[XLEN:0];
    quo_o = {quo_i[XLEN-2:0], 1'b0};
    if (!diff[XLEN+1]) begin
      acc_o = diff[XLEN:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle DIV/DIVU/REM/REMU, BPC quotient bits per cycle.
// Rev 1.0
`default_nettype none

module iterative_divider
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BPC   = 1,
  parameter int TAG_W = 6
) (
  input  logic             core_clock_i,
  input  logic             core_reset_n_i,
  input  logic             core_flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [XLEN-1:0]  req_a_i,
  input  logic [XLEN-1:0]  req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [XLEN-1:0]  rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_dbz_o,
  output logic             rsp_ovf_o
);

  localparam int STEPS = XLEN / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  div_state_e        state_q, state_d;
  logic [XLEN:0]     acc_q, acc_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  div_op_e           op;
  logic              op_signed;
  logic              op_rem;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  logic [BPC:0][XLEN:0]   acc_chain;
  logic [BPC:0][XLEN-1:0] quo_chain;

  assign op        = div_op_e'(req_op_i);
  assign op_signed = is_signed(op);
  assign op_rem    = is_rem(op);
  assign a_neg     = op_signed & req_a_i[XLEN-1];
  assign b_neg     = op_signed & req_b_i[XLEN-1];
  // |MIN| wraps back to MIN, which is the correct unsigned magnitude.
  assign a_abs     = a_neg ? -req_a_i : req_a_i;
  assign b_abs     = b_neg ? -req_b_i : req_b_i;

  assign acc_chain[0] = acc_q;
  assign quo_chain[0] = quo_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    div_step #(
      .XLEN (XLEN)
    ) u_step (
      .acc_i (acc_chain[i]),
      .quo_i (quo_chain[i]),
      .div_i (div_q),
      .acc_o (acc_chain[i+1]),
      .quo_o (quo_chain[i+1])
    );
  end

  assign quo_fix = neg_quo_q ? -quo_chain[BPC] : quo_chain[BPC];
  assign rem_fix = neg_rem_q ? -acc_chain[BPC][XLEN-1:0] : acc_chain[BPC][XLEN-1:0];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    tag_d     = tag_q;
    data_d    = data_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !core_flush_i) begin
          tag_d     = req_tag_i;
          is_rem_d  = op_rem;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (req_b_i == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            data_d  = op_rem ? req_a_i : '1;
          end else if (op_signed && (req_a_i == MIN_VAL) && (req_b_i == '1)) begin
            state_d = DONE;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            data_d  = op_rem ? '0 : MIN_VAL;
          end else begin
            state_d = BUSY;
            acc_d   = '0;
            quo_d   = a_abs;
            div_d   = b_abs;
            cnt_d   = '0;
          end
        end
      end
      BUSY: begin
        acc_d = acc_chain[BPC];
        quo_d = quo_chain[BPC];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          data_d  = is_rem_q ? rem_fix : quo_fix;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (core_flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge core_clock_i) begin
    if (!core_reset_n_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_data_o  = data_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_dbz_o   = dbz_q;
  assign rsp_ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: drives a BPC=1 and a BPC=4 divider in lockstep and checks both.
// Rev 1.0
`default_nettype none

module tb_iterative_divider;
  import div_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic [1:0]        req_op = 2'b00;
  logic [XLEN-1:0]   req_a = '0;
  logic [XLEN-1:0]   req_b = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              rsp_ready = 1'b0;

  logic              rdy1, val1, dbz1, ovf1;
  logic [XLEN-1:0]   data1;
  logic [TAG_W-1:0]  tag1;
  logic              rdy4, val4, dbz4, ovf4;
  logic [XLEN-1:0]   data4;
  logic [TAG_W-1:0]  tag4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iterative_divider #(.XLEN(XLEN), .BPC(1), .TAG_W(TAG_W)) u_dut1 (
    .core_clock_i(clk), .core_reset_n_i(rst_n), .core_flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(rdy1), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .rsp_valid_o(val1), .rsp_ready_i(rsp_ready), .rsp_data_o(data1),
    .rsp_tag_o(tag1), .rsp_dbz_o(dbz1), .rsp_ovf_o(ovf1)
  );

  iterative_divider #(.XLEN(XLEN), .BPC(4), .TAG_W(TAG_W)) u_dut4 (
    .core_clock_i(clk), .core_reset_n_i(rst_n), .core_flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(rdy4), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
    .rsp_valid_o(val4), .rsp_ready_i(rsp_ready), .rsp_data_o(data4),
    .rsp_tag_o(tag4), .rsp_dbz_o(dbz4), .rsp_ovf_o(ovf4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V divide semantics from plain SV arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] d, output logic dz, output logic ov);
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    dz = 1'b0;
    ov = 1'b0;
    if (y == 32'd0) begin
      dz = 1'b1;
      d  = op[1] ? x : 32'hFFFF_FFFF;
    end else if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      ov = 1'b1;
      d  = op[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (op)
        2'b00:   d = sx / sy;
        2'b01:   d = x / y;
        2'b10:   d = sx % sy;
        default: d = x % y;
      endcase
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TAG_W-1:0] t, input logic [31:0] ed, input logic edz,
                        input logic eov, input string nm);
    int lat1 = -1;
    int lat4 = -1;
    int exp1;
    int exp4;
    logic [31:0] d1c = '0, d4c = '0;
    logic [TAG_W-1:0] t1c = '0, t4c = '0;
    logic z1c = 1'b0, z4c = 1'b0, o1c = 1'b0, o4c = 1'b0;
    exp1 = (edz || eov) ? 1 : XLEN + 1;
    exp4 = (edz || eov) ? 1 : XLEN / 4 + 1;
    check({nm, " req_ready"}, {62'd0, rdy1, rdy4}, 64'd3);
    req_valid = 1'b1; req_op = op; req_a = x; req_b = y; req_tag = t; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 100 && (lat1 < 0 || lat4 < 0); c++) begin
      if (lat1 < 0 && val1) begin
        lat1 = c; d1c = data1; t1c = tag1; z1c = dbz1; o1c = ovf1;
      end
      if (lat4 < 0 && val4) begin
        lat4 = c; d4c = data4; t4c = tag4; z4c = dbz4; o4c = ovf4;
      end
      if (lat1 < 0 || lat4 < 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check({nm, " data b1"}, 64'(d1c), 64'(ed));
    check({nm, " data b4"}, 64'(d4c), 64'(ed));
    check({nm, " dbz/ovf b1"}, {62'd0, z1c, o1c}, {62'd0, edz, eov});
    check({nm, " dbz/ovf b4"}, {62'd0, z4c, o4c}, {62'd0, edz, eov});
    check({nm, " tag"}, {52'd0, t1c, t4c}, {52'd0, t, t});
    check({nm, " latency b1"}, 64'(lat1), 64'(exp1));
    check({nm, " latency b4"}, 64'(lat4), 64'(exp4));
    check({nm, " idle after"}, {60'd0, val1, val4, rdy1, rdy4}, 64'd3);
  endtask

  task automatic wait_both_valid(input string nm);
    int n = 0;
    while (!(val1 && val4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " wait valid"}, {62'd0, val1, val4}, 64'd3);
  endtask

  task automatic watch_silent(input int cycles, input string nm);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (val1 || val4) seen++;
    end
    check({nm, " no response"}, 64'(seen), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] md, ra, rb;
    logic mz, mo;
    logic [1:0] rop;
    int mode;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0};
    vecs[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b1};
    vecs[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[10] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset ready/valid", {60'd0, rdy1, rdy4, val1, val4}, 64'hC);
    check("reset data", {data1, data4}, 64'd0);
    check("reset tag/dbz/ovf", {48'd0, tag1, tag4, dbz1, dbz4, ovf1, ovf4}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].d, vecs[i].dz,
             vecs[i].ov, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0:       rb = 32'd0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3, 4: begin
          rb = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, md, mz, mo);
      run_op(rop, ra, rb, TAG_W'($urandom), md, mz, mo, $sformatf("rand%0d", i));
    end

    // Backpressure: hold the result for 10 cycles.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7; req_tag = 6'd42;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_both_valid("bp");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d data", k), {data1, data4}, {32'd14, 32'd14});
      check($sformatf("bp hold%0d ctl", k), {48'd0, tag1, tag4, val1, val4, rdy1, rdy4},
            {48'd0, 6'd42, 6'd42, 4'b1100});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release", {60'd0, val1, val4, rdy1, rdy4}, 64'd3);

    // Flush while busy.
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7; req_tag = 6'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy before flush", {62'd0, rdy1, rdy4}, 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy idle", {60'd0, val1, val4, rdy1, rdy4}, 64'd3);
    watch_silent(40, "flush busy");

    // Flush in DONE with rsp_ready high discards the result.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'b00; req_a = 32'd9; req_b = 32'd0; req_tag = 6'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_both_valid("flush done");
    flush = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush done idle", {60'd0, val1, val4, rdy1, rdy4}, 64'd3);
    watch_silent(5, "flush done");

    // Flush in the accept cycle drops the request.
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'd5; req_b = 32'd0; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush accept idle", {60'd0, val1, val4, rdy1, rdy4}, 64'd3);
    watch_silent(5, "flush accept");

    // Reset clears held outputs.
    run_op(2'b01, 32'd1000, 32'd3, 6'd33, 32'd333, 1'b0, 1'b0, "pre-reset");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("re-reset outputs", {data1, 26'd0, tag1}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Parametrised multi-cycle integer divider for the IXU; successor to the single-width radix-2 divider.
- Supports all four RISC-V divide ops (DIV, DIVU, REM, REMU).
- Configurable width (XLEN) and bits retired per cycle (radix 2^BPC), with tagged valid/ready handshakes on both sides and a flush that kills in-flight work.
- Sits beside the ALU pipes; the issue stage drives the request side and writeback drives the response side.

Parameters:
- XLEN, 32: operand/result width; must be a multiple of BPC.
- BPC, 1: quotient bits retired per cycle; legal values 1, 2, 4.
- TAG_W, 6: width of the opaque tag (ROB index) carried with each request.

Ports:
- core_clock_i  in  1  clock.
- core_reset_n_i  in  1  one clock; reset is synchronous and active-low.
- core_flush_i  in  1  synchronous kill of the in-flight/held operation.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  divider can accept a request.
- req_op_i  in  2  op code: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_a_i  in  XLEN  dividend.
- req_b_i  in  XLEN  divisor.
- req_tag_i  in  TAG_W  request tag.
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts result.
- rsp_data_o  out  XLEN  quotient or remainder.
- rsp_tag_o  out  TAG_W  tag of the result.
- rsp_dbz_o  out  1  divisor was zero.
- rsp_ovf_o  out  1  signed overflow (MIN / -1).

Behaviour:
- Reset values (core_reset_n_i low at a clock edge):
  - state = IDLE.
  - req_ready_o = 1 (combinational from IDLE).
  - rsp_valid_o = 0.
  - rsp_data_o, rsp_tag_o, rsp_dbz_o, rsp_ovf_o = 0.
- Priority: reset > flush > everything else.
- States: IDLE, BUSY, DONE.
- req_ready_o = (state == IDLE). No overlap between operations.
- Accept when req_valid_i & req_ready_o & ~core_flush_i. A flush in the same cycle drops the request.
- On accept, decode op and latch tag. Signed ops take the absolute values of a and b. Latch:
  - neg_q = a[MSB] ^ b[MSB] (signed ops only).
  - neg_r = a[MSB] (signed ops only).
  - is_rem.
- Special cases are resolved at accept. Go straight to DONE, so rsp_valid_o rises the next cycle (latency 1):
  - b == 0: dbz = 1, data = REM/REMU ? a : all-ones.
  - Signed op with a == MIN and b == all-ones: ovf = 1, data = REM ? 0 : MIN.
- Normal path, ACC/QUO registers:
  - Initialise acc = 0 (XLEN+1 bits) and quo = |a|; counter cnt = 0; go to BUSY.
  - Each BUSY cycle applies BPC chained restoring steps: shift {acc,quo} left 1, try acc - b; if non-negative, commit and set quo LSB = 1.
  - cnt increments each cycle. On cnt == XLEN/BPC - 1, the final steps feed the sign fix-up:
    - Quotient is negated if neg_q.
    - Remainder is negated if neg_r (remainder sign follows the dividend).
  - The selected result is registered and the block moves to DONE.
  - Latency: accept at cycle 0; rsp_valid_o high at cycle XLEN/BPC + 1 (33 for 32/1, 9 for 32/4).
- DONE: rsp_valid_o = 1; all rsp_* outputs held stable until rsp_ready_i. On the handshake, go to IDLE with rsp_valid_o = 0 next cycle.
- Backpressure: an arbitrarily long stall in DONE holds outputs unchanged.
- core_flush_i in any state: next state IDLE, rsp_valid_o = 0. A result held in DONE is discarded even if rsp_ready_i is high the same cycle.
- rsp_dbz_o and rsp_ovf_o are 0 for normal results and are mutually exclusive.
- Counter width: $clog2(XLEN/BPC), minimum 1 bit.

Decomposition:
- Package div_pkg holds:
  - div_op_e enum: DIV, DIVU, REM, REMU.
  - div_state_e enum: IDLE, BUSY, DONE.
  - Helpers is_signed(op) and is_rem(op).
- Sub-module div_step: one combinational restoring step with inputs acc, quo, divisor and outputs acc', quo'. It is instantiated BPC times in a chain via a generate loop.

Test Plan:
- XLEN=32, BPC=1, DIVU a=100, b=7 → rsp_data_o=14 at cycle 33 after accept, dbz=0, ovf=0; REMU same operands → 2.
- DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); REM a=7, b=-2 → 1.
- DIV a=5, b=0 → all-ones, dbz=1, rsp_valid_o one cycle after accept; REMU a=5, b=0 → 5, dbz=1.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000, ovf=1; REM → 0, ovf=1; DIVU same operands → 0, ovf=0, full latency.
- Hold rsp_ready_i low for 10 cycles after rsp_valid_o → data/tag stable, req_ready_o=0; then ready=1 → rsp_valid_o=0 and req_ready_o=1 next cycle.
- Flush at BUSY cycle 5, then at DONE with rsp_ready_i=1 → no response emitted, IDLE next cycle; repeat the first scenario with BPC=4 → result 14 at cycle 9.
